// File: rtl/pdec_irq_pkg.sv
// Shared definitions for the pdec interrupt aggregation block: register offsets,
// source type encoding and the coalescing configuration layout.
package pdec_irq_pkg;

  localparam logic [31:0] OFF_RAW      = 32'h00;
  localparam logic [31:0] OFF_STATUS   = 32'h04;
  localparam logic [31:0] OFF_MASK     = 32'h08;
  localparam logic [31:0] OFF_CLR      = 32'h0C;
  localparam logic [31:0] OFF_SET      = 32'h10;
  localparam logic [31:0] OFF_TYPE     = 32'h14;
  localparam logic [31:0] OFF_OVF      = 32'h18;
  localparam logic [31:0] OFF_PEND_ID  = 32'h1C;
  localparam logic [31:0] OFF_GRP_EN   = 32'h20;
  localparam logic [31:0] OFF_COAL_CFG = 32'h30;

  localparam int PEND_VALID_BIT = 31;

  typedef enum logic {
    TYPE_LEVEL = 1'b0,
    TYPE_EDGE  = 1'b1
  } irq_type_e;

  // COAL_CFG layout: [23:8] timeout, [7:0] threshold.
  typedef struct packed {
    logic [15:0] tmo;
    logic [7:0]  thr;
  } coal_cfg_t;

endpackage

// File: rtl/pdec_irq_grp_out.sv
// One routable group output: OR of the group's pending sources, optionally
// coalesced by an event-count threshold and a pending timeout (PDEC_IRQ_COAL_EN).
module pdec_irq_grp_out
  import pdec_irq_pkg::*;
#(
  parameter int INT_NUM = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INT_NUM-1:0] status,
  input  logic [INT_NUM-1:0] grp_en,
`ifdef PDEC_IRQ_COAL_EN
  input  coal_cfg_t          cfg,
  input  logic [INT_NUM-1:0] rise,
`endif
  output logic               intr
);

  logic [INT_NUM-1:0] pending;
  assign pending = status & grp_en;

`ifdef PDEC_IRQ_COAL_EN
  logic [7:0]  cnt, cnt_n;
  logic [15:0] timer;
  logic [5:0]  n_rise;
  logic [8:0]  cnt_sum;
  logic        fire;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    n_rise = '0;
    for (int i = 0; i < INT_NUM; i++) n_rise = n_rise + 6'(rise[i] & grp_en[i]);
    // A rise on an idle group must still count, so the clear applies to the old value only.
    cnt_sum = {1'b0, (|pending) ? cnt : 8'd0} + 9'(n_rise);
    cnt_n   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    fire    = (|pending) && ((cfg.thr == 8'd0) || (cnt >= cfg.thr) ||
                             ((cfg.tmo != 16'd0) && (timer >= cfg.tmo)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      timer <= '0;
      intr  <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      timer <= (|pending) ? ((timer == 16'hFFFF) ? timer : timer + 16'd1) : 16'd0;
      intr  <= (|pending) && (intr || fire);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) intr <= 1'b0;
    else     intr <= |pending;
  end
`endif

endmodule

// File: rtl/pdec_irq_ctrl.sv
// Parametrised interrupt aggregation: raw/mask/status/clr/set, level/edge typing,
// overflow capture, pending-ID and GRP_NUM group outputs. Coalescing: PDEC_IRQ_COAL_EN.
module pdec_irq_ctrl
  import pdec_irq_pkg::*;
#(
  parameter int          INT_NUM   = 8,
  parameter int          GRP_NUM   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic               ren,
  input  logic [31:0]        waddr,
  input  logic [31:0]        raddr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [INT_NUM-1:0] int_src,
  output logic [GRP_NUM-1:0] intr_group
);

  logic [INT_NUM-1:0] raw, raw_n, mask, typ, ovf, ovf_n, src_d;
  logic [INT_NUM-1:0] status, hw_evt, wbits;
  logic [INT_NUM-1:0] grp_en [GRP_NUM];
  logic [31:0]        woff, roff, rd_val, pend_id;
  logic               wr_mask, wr_clr, wr_set, wr_type, wr_ovf;
  logic [GRP_NUM-1:0] wr_grp;

  assign woff   = waddr - BASE_ADDR;
  assign roff   = raddr - BASE_ADDR;
  assign wbits  = wdata[INT_NUM-1:0];
  assign status = raw & ~mask;

  assign wr_mask = wen && (woff == OFF_MASK);
  assign wr_clr  = wen && (woff == OFF_CLR);
  assign wr_set  = wen && (woff == OFF_SET);
  assign wr_type = wen && (woff == OFF_TYPE);
  assign wr_ovf  = wen && (woff == OFF_OVF);

  always_comb begin
    wr_grp = '0;
    for (int g = 0; g < GRP_NUM; g++) wr_grp[g] = wen && (woff == OFF_GRP_EN + 32'(4 * g));
  end

  // Hardware events outrank CLR, so a held level source cannot be cleared.
  always_comb begin
    for (int i = 0; i < INT_NUM; i++)
      hw_evt[i] = (typ[i] == TYPE_EDGE) ? (int_src[i] & ~src_d[i]) : int_src[i];
    raw_n = hw_evt | (wr_clr ? (raw & ~wbits) : raw) | (wr_set ? wbits : '0);
    ovf_n = (hw_evt & raw & typ) | (wr_ovf ? (ovf & ~wbits) : ovf);
  end

  always_comb begin
    pend_id = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) if (status[i]) pend_id[4:0] = 5'(i);
    pend_id[PEND_VALID_BIT] = |status;
  end

`ifdef PDEC_IRQ_COAL_EN
  coal_cfg_t coal_cfg;
  logic      wr_coal;
  assign wr_coal = wen && (woff == OFF_COAL_CFG);
`endif

  always_comb begin
    rd_val = '0;
    case (roff)
      OFF_RAW:      rd_val = 32'(raw);
      OFF_STATUS:   rd_val = 32'(status);
      OFF_MASK:     rd_val = 32'(mask);
      OFF_TYPE:     rd_val = 32'(typ);
      OFF_OVF:      rd_val = 32'(ovf);
      OFF_PEND_ID:  rd_val = pend_id;
`ifdef PDEC_IRQ_COAL_EN
      OFF_COAL_CFG: rd_val = 32'(coal_cfg);
`endif
      default:      rd_val = '0;
    endcase
    for (int g = 0; g < GRP_NUM; g++)
      if (roff == OFF_GRP_EN + 32'(4 * g)) rd_val = 32'(grp_en[g]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw   <= '0;
      mask  <= '1;
      typ   <= '0;
      ovf   <= '0;
      src_d <= '0;
      rdata <= '0;
      // NOTE: the GRP_EN array is a handful of flops, not a RAM, so it is reset element by element.
      for (int g = 0; g < GRP_NUM; g++) grp_en[g] <= '0;
`ifdef PDEC_IRQ_COAL_EN
      coal_cfg <= '0;
`endif
    end else begin
      raw   <= raw_n;
      ovf   <= ovf_n;
      src_d <= int_src;
      if (wr_mask) mask <= wbits;
      if (wr_type) typ  <= wbits;
      for (int g = 0; g < GRP_NUM; g++) if (wr_grp[g]) grp_en[g] <= wbits;
`ifdef PDEC_IRQ_COAL_EN
      if (wr_coal) coal_cfg <= wdata[23:0];
`endif
      if (ren) rdata <= rd_val;
    end
  end

`ifdef PDEC_IRQ_COAL_EN
  logic [INT_NUM-1:0] rise;
  assign rise = raw_n & ~raw & ~mask;
`endif

  for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
    pdec_irq_grp_out #(.INT_NUM(INT_NUM)) u_grp (
      .clk    (clk),
      .rst    (rst),
      .status (status),
      .grp_en (grp_en[g]),
`ifdef PDEC_IRQ_COAL_EN
      .cfg    (coal_cfg),
      .rise   (rise),
`endif
      .intr   (intr_group[g])
    );
  end

endmodule

// File: tb/tb_pdec_irq_ctrl.sv
// Directed self-checking bench for pdec_irq_ctrl (INT_NUM=8, GRP_NUM=2, non-zero base).
// Coalescing checks are compiled in when PDEC_IRQ_COAL_EN is defined.
module tb_pdec_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] waddr = '0, raddr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  int_src = '0;
  logic [1:0]  intr_group;
  logic [31:0] d, held;

  int n_checks = 0;
  int n_errors = 0;

  pdec_irq_ctrl #(.INT_NUM(8), .GRP_NUM(2), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .ren        (ren),
    .waddr      (waddr),
    .raddr      (raddr),
    .wdata      (wdata),
    .rdata      (rdata),
    .int_src    (int_src),
    .intr_group (intr_group)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] val);
    wen = 1'b1; waddr = BASE + off; wdata = val;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] val);
    ren = 1'b1; raddr = BASE + off;
    tick();
    ren = 1'b0;
    val = rdata;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    rd(32'h08, d); check("reset_mask", d, 32'h0000_00FF);
    rd(32'h00, d); check("reset_raw", d, 32'h0);
    rd(32'h1C, d); check("reset_pend_id", d, 32'h0);
    check("reset_intr", 32'(intr_group), 32'h0);
    ren = 1'b1; raddr = 32'h0000_0000; tick(); ren = 1'b0;
    check("unmapped_below_base", rdata, 32'h0);

    // Level pulse on source 0 routed to group 0
    wr(32'h14, 32'h0);
    wr(32'h08, 32'hFE);
    wr(32'h20, 32'h01);
    int_src[0] = 1'b1; tick(); int_src[0] = 1'b0;
    rd(32'h00, d); check("pulse_raw", d, 32'h01);
    check("pulse_intr", 32'(intr_group), 32'h1);
    rd(32'h04, d); check("pulse_status", d, 32'h01);
    wr(32'h0C, 32'h01);
    check("clr_intr_lag", 32'(intr_group), 32'h1);
    tick();
    check("clr_intr", 32'(intr_group), 32'h0);
    rd(32'h00, d); check("clr_raw", d, 32'h0);

    // Edge source 2 held high, then a second rising edge overflows
    wr(32'h14, 32'h04);
    int_src[2] = 1'b1; repeat (5) tick(); int_src[2] = 1'b0;
    rd(32'h00, d); check("edge_raw_once", d, 32'h04);
    rd(32'h18, d); check("edge_no_ovf", d, 32'h0);
    int_src[2] = 1'b1; tick(); int_src[2] = 1'b0; tick();
    rd(32'h18, d); check("edge_ovf", d, 32'h04);
    wr(32'h18, 32'h04);
    rd(32'h18, d); check("ovf_w1c", d, 32'h0);
    wr(32'h0C, 32'h04);
    rd(32'h00, d); check("edge_clr", d, 32'h0);

    // Level source 3 held high resists CLR and never overflows
    int_src[3] = 1'b1; tick();
    wr(32'h0C, 32'h08);
    rd(32'h00, d); check("level_hold_raw", d, 32'h08);
    rd(32'h18, d); check("level_no_ovf", d, 32'h0);
    int_src[3] = 1'b0;
    wr(32'h0C, 32'h08);
    rd(32'h00, d); check("level_release_clr", d, 32'h0);

    // PEND_ID and multi-group routing
    wr(32'h08, 32'h0);
    wr(32'h20, 32'h10);
    wr(32'h24, 32'h30);
    wr(32'h10, 32'h30);
    rd(32'h1C, d); check("pend_id_4", d, 32'h8000_0004);
    check("route_both", 32'(intr_group), 32'h3);
    wr(32'h0C, 32'h10);
    rd(32'h1C, d); check("pend_id_5", d, 32'h8000_0005);
    check("route_grp1", 32'(intr_group), 32'h2);
    wr(32'h0C, 32'h20);
    rd(32'h1C, d); check("pend_id_none", d, 32'h0);
    check("route_none", 32'(intr_group), 32'h0);
    rd(32'h24, d); check("grp_en1_rb", d, 32'h30);

    // Write/read boundaries
    wr(32'h00, 32'hFF);
    rd(32'h00, d); check("raw_ro", d, 32'h0);
    wr(32'h08, 32'hFFFF_FFFF);
    rd(32'h08, d); check("mask_upper_bits", d, 32'hFF);
    wen = 1'b1; waddr = BASE + 32'h08; wdata = 32'h5A;
    ren = 1'b1; raddr = BASE + 32'h08;
    tick();
    wen = 1'b0; ren = 1'b0;
    check("rw_same_addr", rdata, 32'hFF);
    held = rdata;
    tick(); tick();
    check("rdata_hold", rdata, held);
    rd(32'h08, d); check("rw_new_value", d, 32'h5A);
    rd(32'h40, d); check("unmapped", d, 32'h0);

    // Reset mid-operation
    wr(32'h14, 32'h0F);
    wr(32'h10, 32'h81);
    wr(32'h18, 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_intr", 32'(intr_group), 32'h0);
    rd(32'h00, d); check("rst_raw", d, 32'h0);
    rd(32'h14, d); check("rst_type", d, 32'h0);
    rd(32'h24, d); check("rst_grp_en1", d, 32'h0);
    rd(32'h08, d); check("rst_mask", d, 32'hFF);

`ifdef PDEC_IRQ_COAL_EN
    // Threshold coalescing on group 1
    wr(32'h08, 32'h0);
    wr(32'h24, 32'hFF);
    wr(32'h30, 32'h03);
    wr(32'h10, 32'h01); check("thr_set1", 32'(intr_group), 32'h0);
    tick();             check("thr_after1", 32'(intr_group), 32'h0);
    wr(32'h10, 32'h02); check("thr_set2", 32'(intr_group), 32'h0);
    tick();             check("thr_after2", 32'(intr_group), 32'h0);
    wr(32'h10, 32'h04); check("thr_set3", 32'(intr_group), 32'h0);
    tick();             check("thr_fire", 32'(intr_group), 32'h2);
    wr(32'h0C, 32'hFF);
    tick();             check("thr_drop", 32'(intr_group), 32'h0);

    // Timeout coalescing: threshold 5 never reached, timeout 10
    wr(32'h30, 32'h0000_0A05);
    rd(32'h30, d); check("coal_cfg_rb", d, 32'h0A05);
    wr(32'h10, 32'h01);
    repeat (10) tick();
    check("tmo_not_yet", 32'(intr_group), 32'h0);
    tick();
    check("tmo_fire", 32'(intr_group), 32'h2);
    wr(32'h0C, 32'hFF);
    tick();
    check("tmo_drop", 32'(intr_group), 32'h0);

    // Threshold zero fires on the first pending cycle
    wr(32'h30, 32'hFFFF_FFFF);
    rd(32'h30, d); check("coal_cfg_width", d, 32'h00FF_FFFF);
    wr(32'h30, 32'h0);
    wr(32'h10, 32'h01);
    tick();
    check("thr0_fire", 32'(intr_group), 32'h2);
`else
    wr(32'h30, 32'hFFFF_FFFF);
    rd(32'h30, d); check("no_coal_cfg", d, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
